// File: rtl/if_fetch_stage_if.sv
// Bundles the fetch stage's control, instruction-memory and IF/ID signals.
// The fetch stage connects through the master modport. The hazard unit, the
// instruction memory and the decode stage connect through the slave modport.
interface if_fetch_stage_if #(
  parameter int IM_AW = 10,
  parameter int XLEN  = 32
);
  logic             stall_i;
  logic             redirect_i;
  logic [XLEN-1:0]  redirect_pc_i;
  logic             halt_i;
  logic [XLEN-1:0]  im_data_i;
  logic             im_read_o;
  logic [IM_AW-1:0] im_addr_o;
  logic [XLEN-1:0]  if_id_pc_o;
  logic [XLEN-1:0]  if_id_inst_o;
  logic             if_id_valid_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, halt_i, im_data_i,
    output im_read_o, im_addr_o, if_id_pc_o, if_id_inst_o, if_id_valid_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, halt_i, im_data_i,
    input  im_read_o, im_addr_o, if_id_pc_o, if_id_inst_o, if_id_valid_o
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. It owns the PC, reads the zero-latency instruction
// memory and loads the IF/ID register. It also handles stall, redirect and halt.
// The optional macro IF_PERF_CNT_EN adds fetch and stall performance counters.
module if_fetch_stage #(
  parameter int              IM_AW    = 10,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst,
  if_fetch_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] if_id_pc_reg, if_id_pc_next;
  logic [XLEN-1:0] if_id_inst_reg, if_id_inst_next;
  logic            if_id_valid_reg, if_id_valid_next;
  logic            capture;
  logic            im_read;

  // State, PC and IF/ID register update. A reset overrides any stall or halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      if_id_pc_reg    <= '0;
      if_id_inst_reg  <= '0;
      if_id_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      if_id_pc_reg    <= if_id_pc_next;
      if_id_inst_reg  <= if_id_inst_next;
      if_id_valid_reg <= if_id_valid_next;
    end
  end

  // Next-state logic. The priority is redirect, then halt, then stall, then a
  // normal fetch. BOOT spends one idle cycle while the memory's reset-zero
  // output clears.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    if_id_pc_next    = if_id_pc_reg;
    if_id_inst_next  = if_id_inst_reg;
    if_id_valid_next = if_id_valid_reg;
    capture          = 1'b0;
    im_read          = 1'b0;
    case (state_reg)
      BOOT: begin
        im_read          = 1'b1;
        if_id_valid_next = 1'b0;
        state_next       = RUN;
      end
      RUN: begin
        im_read = ~bus.stall_i;
        if (bus.redirect_i) begin
          pc_next          = bus.redirect_pc_i & ALIGN_MASK;
          if_id_valid_next = 1'b0;
          if_id_inst_next  = '0;
        end else if (bus.halt_i) begin
          capture    = ~bus.stall_i;
          state_next = HALT;
        end else if (!bus.stall_i) begin
          capture = 1'b1;
          pc_next = pc_reg + PC_STEP;
        end
      end
      HALT: begin
        if_id_valid_next = 1'b0;
        if (bus.redirect_i) begin
          pc_next         = bus.redirect_pc_i & ALIGN_MASK;
          if_id_inst_next = '0;
          state_next      = RUN;
        end
      end
      default: state_next = BOOT;
    endcase
    if (capture) begin
      if_id_pc_next    = pc_reg;
      if_id_inst_next  = bus.im_data_i;
      if_id_valid_next = 1'b1;
    end
  end

  assign bus.im_read_o     = im_read & ~rst;
  assign bus.im_addr_o     = pc_reg[IM_AW+1:2];
  assign bus.if_id_pc_o    = if_id_pc_reg;
  assign bus.if_id_inst_o  = if_id_inst_reg;
  assign bus.if_id_valid_o = if_id_valid_reg;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_reg, perf_stall_reg;

  // Count IF/ID loads and RUN stall cycles. Both counters wrap at 2**32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_reg <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (capture)
        perf_fetch_reg <= perf_fetch_reg + 32'd1;
      if (state_reg == RUN && bus.stall_i && !bus.redirect_i)
        perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_reg;
  assign perf_stall_cnt_o = perf_stall_reg;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a scoreboard. Stimulus pushes the
// expected IF/ID contents into a queue. A monitor compares them whenever the
// IF/ID register holds a valid instruction.
module tb_if_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] im_mem [0:1023];
  logic [63:0] exp_q [$];

  if_fetch_stage_if #(.IM_AW(10), .XLEN(32)) bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  if_fetch_stage #(.IM_AW(10), .XLEN(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign bus.im_data_i = im_mem[bus.im_addr_o];

  function automatic logic [31:0] iw(input int k);
    return 32'h1000_0000 + k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor. It checks every cycle in which IF/ID presents a valid instruction.
  always @(negedge clk) begin
    if (bus.if_id_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got pc %08h inst %08h expected none",
                 bus.if_id_pc_o, bus.if_id_inst_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("if_id_pc", bus.if_id_pc_o, e[63:32]);
        chk("if_id_inst", bus.if_id_inst_o, e[31:0]);
        $display("txn pc=%08h inst=%08h", bus.if_id_pc_o, bus.if_id_inst_o);
      end
    end
  end

  // One clock cycle of stimulus. It checks the combinational IM outputs in the
  // cycle, then either queues the expected capture or checks that IF/ID stays
  // empty. zmode 1 also requires inst==0, and zmode 2 also requires pc==0.
  task automatic cyc(input logic rs, input logic s, input logic r, input logic h,
                     input logic [31:0] rpc, input logic exp_rd, input int exp_addr,
                     input logic exp_v, input logic [31:0] exp_pc,
                     input logic [31:0] exp_inst, input int zmode);
    rst               = rs;
    bus.stall_i       = s;
    bus.redirect_i    = r;
    bus.halt_i        = h;
    bus.redirect_pc_i = rpc;
    #1;
    chk("im_read", {31'b0, bus.im_read_o}, {31'b0, exp_rd});
    chk("im_addr", {22'b0, bus.im_addr_o}, exp_addr[31:0]);
    if (exp_v)
      exp_q.push_back({exp_pc, exp_inst});
    @(posedge clk);
    #1;
    if (!exp_v) begin
      chk("valid_low", {31'b0, bus.if_id_valid_o}, 32'h0);
      if (zmode >= 1) chk("inst_zero", bus.if_id_inst_o, 32'h0);
      if (zmode == 2) chk("pc_zero", bus.if_id_pc_o, 32'h0);
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) im_mem[k] = iw(k);
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.halt_i        = 1'b0;
    bus.redirect_pc_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_im_read", {31'b0, bus.im_read_o}, 32'h0);
    chk("rst_valid", {31'b0, bus.if_id_valid_o}, 32'h0);
    chk("rst_pc", bus.if_id_pc_o, 32'h0);
    chk("rst_inst", bus.if_id_inst_o, 32'h0);

    // Run freely after reset. BOOT comes first, then the captures at 0, 4 and 8.
    cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0, iw(0), 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 1, 1, 32'h4, iw(1), 0);
    // Stall for 3 cycles at pc=8. IF/ID holds pc 4.
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0, 0, 32'h0, 0, 2, 1, 32'h4, iw(1), 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 2, 1, 32'h8, iw(2), 0);
    // Halt at pc=12. The instruction there is captured, then IF/ID stays empty.
    // Stall and halt are ignored while in HALT.
    cyc(0, 0, 0, 1, 32'h0, 1, 3, 1, 32'hC, iw(3), 0);
    cyc(0, 1, 0, 1, 32'h0, 0, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0, 3, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h20, 0, 3, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 32'h0, 1, 8, 1, 32'h20, iw(8), 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 9, 1, 32'h24, iw(9), 0);
    // Redirect together with stall. The flush wins, and the low target bits are dropped.
    cyc(0, 1, 1, 0, 32'h43, 0, 10, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 32'h0, 1, 16, 1, 32'h40, iw(16), 0);
    cyc(0, 1, 0, 0, 32'h0, 0, 17, 1, 32'h40, iw(16), 0);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_a", perf_fetch_cnt, 32'd7);
    chk("perf_stall_a", perf_stall_cnt, 32'd4);
`endif
    // Reset in the middle of a stall.
    cyc(1, 1, 0, 0, 32'h0, 0, 17, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0, iw(0), 0);
    // Reset in the middle of HALT.
    cyc(0, 0, 0, 1, 32'h0, 1, 1, 1, 32'h4, iw(1), 0);
    cyc(0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 32'h0, 0, 1, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0, iw(0), 0);
    // The PC wraps after a redirect to the top of the address space.
    cyc(0, 0, 1, 0, 32'hFFFF_FFFC, 1, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 32'h0, 1, 1023, 1, 32'hFFFF_FFFC, iw(1023), 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 0, 1, 32'h0, iw(0), 0);
    cyc(0, 0, 0, 0, 32'h0, 1, 1, 1, 32'h4, iw(1), 0);
    cyc(0, 0, 0, 1, 32'h0, 1, 2, 1, 32'h8, iw(2), 0);
    cyc(0, 0, 0, 0, 32'h0, 0, 2, 0, 0, 0, 0);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_b", perf_fetch_cnt, 32'd5);
    chk("perf_stall_b", perf_stall_cnt, 32'd0);
`endif
    // Allow the monitor to drain the queue, with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline; sits directly upstream of the instruction memory.
- Owns the program counter and drives the IM read enable and word address.
- Captures the combinational IM read data into the IF/ID pipeline register.
- Honours stall, flush/redirect (branch/jump/exception) and halt requests from the hazard unit and later stages.

Parameters:
- IM_AW, 10, IM word-address width; IM depth = 2**IM_AW words.
- XLEN, 32, instruction and PC width.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- stall_i  input  1  hold PC and IF/ID register.
- redirect_i  input  1  flush IF/ID and load redirect_pc_i.
- redirect_pc_i  input  XLEN  redirect target, byte address.
- halt_i  input  1  stop fetching after the current cycle.
- im_data_i  input  XLEN  IM read data, combinational from im_addr_o.
- im_read_o  output  1  IM read enable.
- im_addr_o  output  IM_AW  IM word address = pc[IM_AW+1:2].
- if_id_pc_o  output  XLEN  PC of the registered instruction.
- if_id_inst_o  output  XLEN  registered instruction.
- if_id_valid_o  output  1  registered instruction is valid.

Behaviour:
- Reset is synchronous on rst, active-high, clocked by clk. While rst=1 at a posedge:
  - state<=BOOT, pc<=RESET_PC;
  - if_id_pc_o<=0, if_id_inst_o<=0, if_id_valid_o<=0.
  - im_read_o=0 combinationally while rst=1.
- im_addr_o = pc[IM_AW+1:2] at all times. The IM returns data in the same cycle (zero latency).
- FSM states:
  - BOOT: single cycle after reset release. im_read_o=1. No capture, valid<=0, pc unchanged. Next state RUN. This absorbs the IM's reset-zero output.
  - RUN: im_read_o = ~stall_i. Priority is redirect_i > halt_i > stall_i > normal.
    - Normal: pc<=pc+4; if_id_inst_o<=im_data_i; if_id_pc_o<=pc; if_id_valid_o<=1.
    - stall_i=1: pc and all IF/ID outputs hold their values, including valid.
    - redirect_i=1: pc<={redirect_pc_i[XLEN-1:2],2'b00}; if_id_valid_o<=0; if_id_inst_o<=0. Stall is ignored that cycle; the flush wins.
    - halt_i=1 (no redirect): capture as in the normal case if stall_i=0, else hold. pc holds. Next state HALT.
  - HALT: im_read_o=0; if_id_valid_o<=0; pc holds. Exit only on redirect_i=1, which loads the PC as above and goes to RUN. halt_i and stall_i are ignored in HALT.
- PC arithmetic:
  - pc+4 is modulo 2**XLEN; 32'hFFFF_FFFC wraps to 0.
  - im_addr_o wraps naturally at the IM depth.
  - redirect_pc_i bits [1:0] are discarded.
- Redirect and stall in the same cycle: redirect wins and the bubble enters IF/ID.
- rst asserted mid-operation, including in HALT or during a stall: reset wins unconditionally. Next cycle is BOOT.
- if_id_inst_o is 0 whenever if_id_valid_o=0 after a flush or reset. Downstream treats 0 as a NOP.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- With the macro defined, two ports are added:
  - perf_fetch_cnt_o, output, 32 bits: increments on each cycle in which if_id_valid_o is loaded with 1.
  - perf_stall_cnt_o, output, 32 bits: increments on each RUN cycle with stall_i=1 and redirect_i=0.
  - Both counters clear on rst and wrap at 2**32.
- Without the macro: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then free run, IM preloaded with word k = 32'h1000_0000+k, RESET_PC=0 -> valid first rises 2 cycles after rst falls (BOOT then first capture); if_id_pc_o sequence 0,4,8; if_id_inst_o sequence 32'h1000_0000, 32'h1000_0001, 32'h1000_0002.
- stall_i high for 3 cycles in RUN at pc=8 -> IF/ID holds pc 4 with its instruction; im_read_o=0; pc stays 8; fetch resumes at 8 after stall_i falls.
- redirect_i with redirect_pc_i=32'h0000_0043 while stall_i=1 -> next cycle valid=0 and inst=0; im_addr_o=16 (pc=32'h40); following capture has if_id_pc_o=32'h40.
- halt_i at pc=12 -> instruction at 12 captured; then valid=0 and im_read_o=0 indefinitely; redirect to 32'h20 resumes fetch with if_id_pc_o=32'h20.
- rst asserted mid-HALT and mid-stall -> all outputs zero next cycle; BOOT cycle follows; fetch restarts at RESET_PC.
- PC wrap with redirect to 32'hFFFF_FFFC, IM_AW=10 -> im_addr_o=1023, then 0; if_id_pc_o=32'hFFFF_FFFC then 0. With IF_PERF_CNT_EN, perf_fetch_cnt_o counts exactly these captures.
